// File: rtl/mem_resp.sv
// ============================================================================
// Module   : mem_resp
// Purpose  : Byte-wide memory responder with programmable wait states and a
//            one-cycle ready pulse. Optional macro: MEM_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_resp #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   addr,
    input  logic [DW-1:0] din,
    input  logic          read,
    input  logic          write,
    output logic [DW-1:0] dout,
    output logic          ready,
    output logic          busy,
    output logic          err
);

    localparam logic [3:0] c_wait_init = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_last;
    logic [15:0]   r_addr;
    logic [DW-1:0] r_din;
    logic          r_wr;
    logic [DW-1:0] r_mem [2**AW];

    logic [AW-1:0] w_idx;
    logic          w_access;
    logic          w_oob;

    assign w_idx    = r_addr[AW-1:0];
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0) && r_last;

`ifdef MEM_BOUNDS_CHECK_EN
    logic r_err;
    assign w_oob = ((r_addr >> AW) != 16'd0);
    assign err   = r_err;
`else
    logic [15:0] w_unused_hi;
    assign w_unused_hi = r_addr >> AW;
    assign w_oob       = 1'b0;
    assign err         = 1'b0;
`endif

    // Storage is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_access && r_wr && !w_oob) begin
            r_mem[w_idx] <= r_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b0;
            r_addr  <= 16'd0;
            r_din   <= '0;
            r_wr    <= 1'b0;
            dout    <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (read || write) begin
                        r_addr  <= addr;
                        r_din   <= din;
                        r_wr    <= write;
                        r_cnt   <= c_wait_init;
                        r_last  <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // One settle edge after the count expires so ready lands
                    // WAIT_CYC+2 edges after the request was sampled.
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_last) begin
                        r_last <= 1'b1;
                    end else begin
                        if (!r_wr) begin
                            dout <= w_oob ? {DW{1'b1}} : r_mem[w_idx];
                        end
                        ready   <= 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
                        r_err   <= w_oob;
`endif
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready   <= 1'b0;
                    busy    <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_resp.sv
// ============================================================================
// Module   : tb_mem_resp
// Purpose  : Self-checking bench for mem_resp (table vectors, hand sequences,
//            random requests against a behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_resp;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int WAIT_CYC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   addr = 16'd0;
    logic [DW-1:0] din = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] dout;
    logic          ready;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: byte array, written flags, expected bus data.
    logic [7:0] m_mem   [256];
    bit         m_valid [256];
    logic [7:0] m_dout;
    bit         m_dknown;

    always #5 clk = ~clk;

    mem_resp #(.AW(AW), .DW(DW), .WAIT_CYC(WAIT_CYC)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .din   (din),
        .read  (read),
        .write (write),
        .dout  (dout),
        .ready (ready),
        .busy  (busy),
        .err   (err)
    );

    typedef struct {
        string      name;
        logic       rd;
        logic       wr;
        logic [15:0] a;
        logic [7:0] d;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_apply(input logic rd, input logic wr,
                                         input logic [15:0] a, input logic [7:0] d);
        logic oob;
`ifdef MEM_BOUNDS_CHECK_EN
        oob = (a[15:8] != 8'd0);
`else
        oob = 1'b0;
`endif
        if (wr) begin
            if (!oob) begin
                m_mem[a[7:0]]   = d;
                m_valid[a[7:0]] = 1'b1;
            end
        end else if (rd) begin
            if (oob) begin
                m_dout   = 8'hFF;
                m_dknown = 1'b1;
            end else begin
                m_dout   = m_mem[a[7:0]];
                m_dknown = m_valid[a[7:0]];
            end
        end
        return oob;
    endfunction

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic do_req(input string name, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [7:0] d, input bit swap,
                          output logic [7:0] got_dout, output logic got_err);
        int lat;
        read = rd; write = wr; addr = a; din = d;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        if (swap) begin
            addr = 16'h0002;
            din  = 8'h22;
        end
        check({name, " busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, WAIT_CYC + 2);
        got_dout = dout;
        got_err  = err;
        @(posedge clk); #1;
        check({name, " ready width"}, {30'd0, ready, busy}, 32'd0);
    endtask

    logic [7:0] gd;
    logic       ge;
    logic       eerr;
    vec_t       vt [7];

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_mem[i]   = 8'h00;
        end
        m_dout   = 8'h00;
        m_dknown = 1'b1;

        vt[0] = '{"wr5_init",  1'b0, 1'b1, 16'h0005, 8'h00, 8'h00, 1'b0};
        vt[1] = '{"wr3",       1'b0, 1'b1, 16'h0003, 8'hA5, 8'h00, 1'b0};
        vt[2] = '{"rd3",       1'b1, 1'b0, 16'h0003, 8'h00, 8'hA5, 1'b0};
        vt[3] = '{"rdwr7",     1'b1, 1'b1, 16'h0007, 8'h3C, 8'hA5, 1'b0};
        vt[4] = '{"rd7",       1'b1, 1'b0, 16'h0007, 8'h00, 8'h3C, 1'b0};
`ifdef MEM_BOUNDS_CHECK_EN
        vt[5] = '{"wr105",     1'b0, 1'b1, 16'h0105, 8'h77, 8'h3C, 1'b1};
        vt[6] = '{"rd5",       1'b1, 1'b0, 16'h0005, 8'h00, 8'h00, 1'b0};
`else
        vt[5] = '{"wr105",     1'b0, 1'b1, 16'h0105, 8'h77, 8'h3C, 1'b0};
        vt[6] = '{"rd5_alias", 1'b1, 1'b0, 16'h0005, 8'h00, 8'h77, 1'b0};
`endif

        #12;
        check("reset dout", {24'd0, dout}, 32'd0);
        check("reset flags", {29'd0, ready, busy, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            do_req(vt[i].name, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, 1'b0, gd, ge);
            eerr = model_apply(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d);
            check({vt[i].name, " dout"}, {24'd0, gd}, {24'd0, vt[i].exp_dout});
            check({vt[i].name, " err"}, {31'd0, ge}, {31'd0, vt[i].exp_err});
        end

`ifdef MEM_BOUNDS_CHECK_EN
        do_req("rd105", 1'b1, 1'b0, 16'h0105, 8'h00, 1'b0, gd, ge);
        eerr = model_apply(1'b1, 1'b0, 16'h0105, 8'h00);
        check("rd105 dout", {24'd0, gd}, 32'hFF);
        check("rd105 err", {31'd0, ge}, 32'd1);
`endif

        // dout must hold after the read strobe has gone away
        do_req("rd3b", 1'b1, 1'b0, 16'h0003, 8'h00, 1'b0, gd, ge);
        eerr = model_apply(1'b1, 1'b0, 16'h0003, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("dout hold", {24'd0, dout}, 32'hA5);

        // requests changing while busy are ignored
        do_req("wr2", 1'b0, 1'b1, 16'h0002, 8'h99, 1'b0, gd, ge);
        eerr = model_apply(1'b0, 1'b1, 16'h0002, 8'h99);
        do_req("wr1swap", 1'b0, 1'b1, 16'h0001, 8'h11, 1'b1, gd, ge);
        eerr = model_apply(1'b0, 1'b1, 16'h0001, 8'h11);
        do_req("rd1", 1'b1, 1'b0, 16'h0001, 8'h00, 1'b0, gd, ge);
        eerr = model_apply(1'b1, 1'b0, 16'h0001, 8'h00);
        check("busy ignore mem1", {24'd0, gd}, 32'h11);
        do_req("rd2", 1'b1, 1'b0, 16'h0002, 8'h00, 1'b0, gd, ge);
        eerr = model_apply(1'b1, 1'b0, 16'h0002, 8'h00);
        check("busy ignore mem2", {24'd0, gd}, 32'h99);

        // reset in the middle of a write's wait phase
        do_req("wr10", 1'b0, 1'b1, 16'h0010, 8'h00, 1'b0, gd, ge);
        eerr = model_apply(1'b0, 1'b1, 16'h0010, 8'h00);
        write = 1'b1; addr = 16'h0010; din = 8'h5A;
        @(posedge clk); #1;
        write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midreset dout", {24'd0, dout}, 32'd0);
        check("midreset flags", {29'd0, ready, busy, err}, 32'd0);
        m_dout = 8'h00;
        m_dknown = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req("rd10", 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, gd, ge);
        eerr = model_apply(1'b1, 1'b0, 16'h0010, 8'h00);
        check("midreset mem10", {24'd0, gd}, 32'h00);

        // randomized requests against the model
        for (int i = 0; i < 60; i++) begin
            logic        rr, ww;
            logic [15:0] ra;
            logic [7:0]  rdat;
            int          op;
            op   = $urandom_range(0, 2);
            rr   = (op != 0);
            ww   = (op != 1);
            ra   = {($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'($urandom_range(0, 15))};
            rdat = 8'($urandom);
            do_req("rand", rr, ww, ra, rdat, 1'b0, gd, ge);
            eerr = model_apply(rr, ww, ra, rdat);
            if (m_dknown) check("rand dout", {24'd0, gd}, {24'd0, m_dout});
            check("rand err", {31'd0, ge}, {31'd0, eerr});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
